// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch stage that sits directly after the program counter.
// It takes the current PC and issues one word read at a time over a req/gnt
// plus rvalid handshake. It buffers each returned instruction, together with
// its PC, in a small FIFO for the decoder. A taken-branch flush throws away
// everything that is already fetched or still in flight.
//
// Optional feature (compile-time macro IFETCH_ALIGN_CHECK_EN):
//   A misaligned PC (pc[1:0] != 0) does not go to memory. Instead, a faulting
//   entry {instr=0, instr_pc=pc, fetch_fault=1} is pushed into the FIFO.
//   Without the macro, the low PC bits are ignored for the memory address
//   and fetch_fault is tied to 0.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   pc           in   current PC from the PC stage
//   flush        in   taken branch/jump; drops fetched and in-flight work
//   pc_advance   out  one-cycle pulse: the PC may take its next value
//   mem_req      out  memory request valid
//   mem_addr     out  word-aligned request address
//   mem_gnt      in   memory accepted the request this cycle
//   mem_rvalid   in   read data valid (never back-pressured)
//   mem_rdata    in   read data
//   instr_valid  out  FIFO head valid
//   instr        out  FIFO head instruction
//   instr_pc     out  FIFO head PC
//   instr_ready  in   decoder consumes the head on instr_valid & instr_ready
//   fetch_fault  out  misaligned-fetch flag travelling with the head entry
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_advance,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_req_pc, w_req_pc_nxt;
  logic              r_drop, w_drop_nxt;

  logic [DATA_W-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push, w_pop, w_slot_free;
  logic [DATA_W-1:0] w_push_data;
  logic [ADDR_W-1:0] w_push_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic              r_fifo_fault [FIFO_DEPTH];
  logic              w_push_fault;
`endif

  // In IDLE nothing is in flight, so the registered count alone decides
  // whether a slot can be reserved for the next request. A request is only
  // launched from IDLE, which guarantees the response always has a home.
  assign w_slot_free = (r_count < DEPTH_C);

  // A pop in the flush cycle is ignored because flush clears the FIFO anyway.
  assign w_pop = instr_valid & instr_ready & ~flush;

  // -------------------------------------------------------------------------
  // Fetch FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    w_push       = 1'b0;
    w_push_data  = mem_rdata;
    w_push_pc    = r_req_pc;
    pc_advance   = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    w_push_fault = 1'b0;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (!flush && w_slot_free) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            // Push the fault entry directly. The PC is held because no
            // pc_advance is sent; only a flush can redirect it.
            w_push       = 1'b1;
            w_push_data  = '0;
            w_push_pc    = pc;
            w_push_fault = 1'b1;
          end else
`endif
          begin
            w_req_pc_nxt = pc;
            w_state_nxt  = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (mem_gnt) begin
          w_state_nxt = S_WAIT;
          // A flush cannot withdraw a granted request. Mark its response for
          // discard and keep the PC from advancing on the wrong path.
          if (flush) w_drop_nxt = 1'b1;
          else       pc_advance = 1'b1;
        end else if (flush) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
          w_push      = ~r_drop & ~flush;
        end else if (flush) begin
          w_drop_nxt = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req  = (r_state == S_REQ);
  assign mem_addr = {r_req_pc[ADDR_W-1:2], 2'b00};

  // -------------------------------------------------------------------------
  // Fetch FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_req_pc <= '0;
      r_drop   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its inputs from before the edge.
      r_state  <= w_state_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is reset on purpose, because instr and instr_pc
      // must read 0 out of reset. This is cheap at this FIFO depth.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
        r_fifo_fault[i] <= 1'b0;
`endif
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= w_push_data;
        r_fifo_pc[r_wr_ptr]    <= w_push_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
        r_fifo_fault[r_wr_ptr] <= w_push_fault;
`endif
        // The depth is a power of two, so the pointer wraps naturally.
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];

`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_fault = r_fifo_fault[r_rd_ptr];
`else
  assign fetch_fault = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Invariants of the slot-reservation scheme
  // -------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
    !(w_push && !w_pop && (r_count == DEPTH_C)));
  a_count_bound : assert property (@(posedge clock) disable iff (!reset)
    r_count <= DEPTH_C);
  a_adv_no_flush : assert property (@(posedge clock) disable iff (!reset)
    !(pc_advance && flush));

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        pc_advance;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  ifetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .pc_advance  (pc_advance),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_fault (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus plus the outputs expected in that cycle.
  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;   // compared only when e_req = 1
    logic        e_adv;
    logic        e_val;
    logic [31:0] e_instr;  // compared only when e_val = 1
    logic [31:0] e_ipc;    // compared only when e_val = 1
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic fl, input logic g,
                              input logic rv, input logic [31:0] rd, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_adv,
                              input logic e_val, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.pc = p; v.fl = fl; v.gnt = g; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_adv = e_adv;
    v.e_val = e_val; v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic drive(input logic [31:0] p, input logic fl, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    pc = p; flush = fl; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; instr_ready = rdy;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      drive(tbl[i].pc, tbl[i].fl, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      #1;
      check($sformatf("%s[%0d].mem_req", tag, i), 64'(mem_req), 64'(tbl[i].e_req));
      check($sformatf("%s[%0d].pc_advance", tag, i), 64'(pc_advance), 64'(tbl[i].e_adv));
      check($sformatf("%s[%0d].instr_valid", tag, i), 64'(instr_valid), 64'(tbl[i].e_val));
      if (tbl[i].e_req)
        check($sformatf("%s[%0d].mem_addr", tag, i), 64'(mem_addr), 64'(tbl[i].e_addr));
      if (tbl[i].e_val) begin
        check($sformatf("%s[%0d].instr", tag, i), 64'(instr), 64'(tbl[i].e_instr));
        check($sformatf("%s[%0d].instr_pc", tag, i), 64'(instr_pc), 64'(tbl[i].e_ipc));
      end
    end
    tbl.delete();
  endtask

  // Two flush cycles bring the unit to IDLE from any state. A third cycle
  // confirms that the FIFO is empty and that no request is pending.
  task automatic flush_all(input string tag);
    @(negedge clock); drive(32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock); #1;
    check({tag, ".flush.instr_valid"}, 64'(instr_valid), 64'h0);
    check({tag, ".flush.mem_req"}, 64'(mem_req), 64'h0);
  endtask

  // One cycle of hand-written stimulus, followed by the output checks.
  task automatic cyc(input string tag, input logic [31:0] p, input logic fl, input logic g,
                     input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic e_req, input logic e_adv, input logic e_val);
    @(negedge clock);
    drive(p, fl, g, rv, rd, rdy);
    #1;
    check({tag, ".mem_req"}, 64'(mem_req), 64'(e_req));
    check({tag, ".pc_advance"}, 64'(pc_advance), 64'(e_adv));
    check({tag, ".instr_valid"}, 64'(instr_valid), 64'(e_val));
  endtask

  localparam logic [31:0] I0 = 32'h0000_0013, I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_0113, I3 = 32'h0030_0193;

  initial begin
    reset = 1'b0;
    drive(32'h1234, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (2) @(negedge clock);
    #1;
    check("reset.mem_req", 64'(mem_req), 64'h0);
    check("reset.mem_addr", 64'(mem_addr), 64'h0);
    check("reset.pc_advance", 64'(pc_advance), 64'h0);
    check("reset.instr_valid", 64'(instr_valid), 64'h0);
    check("reset.instr", 64'(instr), 64'h0);
    check("reset.instr_pc", 64'(instr_pc), 64'h0);
    check("reset.fetch_fault", 64'(fetch_fault), 64'h0);
    @(negedge clock); reset = 1'b1;   // flush still 1, so the unit holds in IDLE

    // Single fetch with rvalid one cycle after gnt.
    //              pc   fl g  rv rd   rdy req addr adv val instr ipc
    tbl.push_back(mk(0,   0, 1, 0, 0,   1,  0, 0,   0,  0, 0,  0));
    tbl.push_back(mk(0,   0, 1, 0, 0,   1,  1, 0,   1,  0, 0,  0));
    tbl.push_back(mk(4,   0, 0, 1, I0,  1,  0, 0,   0,  0, 0,  0));
    tbl.push_back(mk(4,   0, 0, 0, 0,   1,  0, 0,   0,  1, I0, 0));
    tbl.push_back(mk(4,   0, 0, 0, 0,   1,  1, 4,   0,  0, 0,  0));
    run_table("single");
    flush_all("single");

    // Streaming with gnt and rvalid always high.
    tbl.push_back(mk(0,     0, 1, 1, 0,  1, 0, 0,    0, 0, 0,  0));
    tbl.push_back(mk(0,     0, 1, 1, 0,  1, 1, 0,    1, 0, 0,  0));
    tbl.push_back(mk(4,     0, 1, 1, I0, 1, 0, 0,    0, 0, 0,  0));
    tbl.push_back(mk(4,     0, 1, 1, 0,  1, 0, 0,    0, 1, I0, 0));
    tbl.push_back(mk(4,     0, 1, 1, 0,  1, 1, 4,    1, 0, 0,  0));
    tbl.push_back(mk(8,     0, 1, 1, I1, 1, 0, 0,    0, 0, 0,  0));
    tbl.push_back(mk(8,     0, 1, 1, 0,  1, 0, 0,    0, 1, I1, 4));
    tbl.push_back(mk(8,     0, 1, 1, 0,  1, 1, 8,    1, 0, 0,  0));
    tbl.push_back(mk(12,    0, 1, 1, I2, 1, 0, 0,    0, 0, 0,  0));
    tbl.push_back(mk(12,    0, 1, 1, 0,  1, 0, 0,    0, 1, I2, 8));
    tbl.push_back(mk(12,    0, 1, 1, 0,  1, 1, 12,   1, 0, 0,  0));
    tbl.push_back(mk(16,    0, 1, 1, I3, 1, 0, 0,    0, 0, 0,  0));
    tbl.push_back(mk(16,    0, 1, 1, 0,  1, 0, 0,    0, 1, I3, 12));
    run_table("stream");
    flush_all("stream");

    // instr_ready low for 10 cycles: exactly two fetches, then the unit stalls.
    tbl.push_back(mk(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 1, 1, 0,  0, 1, 0, 1, 0, 0,  0));
    tbl.push_back(mk(4, 0, 1, 1, I0, 0, 0, 0, 0, 0, 0,  0));
    tbl.push_back(mk(4, 0, 1, 1, 0,  0, 0, 0, 0, 1, I0, 0));
    tbl.push_back(mk(4, 0, 1, 1, 0,  0, 1, 4, 1, 1, I0, 0));
    tbl.push_back(mk(8, 0, 1, 1, I1, 0, 0, 0, 0, 1, I0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(8, 0, 1, 1, 0, 0, 0, 0, 0, 1, I0, 0));
    tbl.push_back(mk(8, 0, 1, 1, 0,  1, 0, 0, 0, 1, I0, 0));
    tbl.push_back(mk(8, 0, 1, 1, 0,  1, 0, 0, 0, 1, I1, 4));
    tbl.push_back(mk(8, 0, 1, 1, 0,  1, 1, 8, 1, 0, 0,  0));
    run_table("stall");
    flush_all("stall");

    // Grant withheld for 5 cycles: the address stays stable and no advance occurs.
    cyc("gnt.idle", 32'h20, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("gnt.wait%0d", k), 32'h20 + 32'(k), 0, 0, 0, 0, 1, 1, 0, 0);
      check($sformatf("gnt.wait%0d.mem_addr", k), 64'(mem_addr), 64'h20);
    end
    cyc("gnt.grant", 32'h20, 0, 1, 0, 0, 1, 1, 1, 0);
    cyc("gnt.resp", 32'h24, 0, 0, 1, 32'h0AA0_0013, 1, 0, 0, 0);
    cyc("gnt.out", 32'h24, 0, 0, 0, 0, 1, 0, 0, 1);
    check("gnt.out.instr", 64'(instr), 64'h0AA0_0013);
    check("gnt.out.instr_pc", 64'(instr_pc), 64'h20);
    flush_all("gnt");

    // Flush in WAIT: the response is dropped, then the redirected fetch works.
    cyc("fw.idle", 32'h10, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc("fw.req", 32'h10, 0, 1, 0, 0, 1, 1, 1, 0);
    cyc("fw.flush", 32'h14, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc("fw.stale", 32'h40, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    cyc("fw.empty", 32'h40, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc("fw.req2", 32'h40, 0, 1, 0, 0, 1, 1, 1, 0);
    check("fw.req2.mem_addr", 64'(mem_addr), 64'h40);
    cyc("fw.resp", 32'h44, 0, 0, 1, 32'h1234_5013, 1, 0, 0, 0);
    cyc("fw.out", 32'h44, 0, 0, 0, 0, 1, 0, 0, 1);
    check("fw.out.instr", 64'(instr), 64'h1234_5013);
    check("fw.out.instr_pc", 64'(instr_pc), 64'h40);
    flush_all("fw");

    // Flush together with gnt in REQ: no advance, and the response is dropped.
    cyc("fg.idle", 32'h50, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("fg.req", 32'h50, 1, 1, 0, 0, 1, 1, 0, 0);
    cyc("fg.resp", 32'h60, 0, 0, 1, 32'hBAD0_0BAD, 1, 0, 0, 0);
    cyc("fg.after", 32'h60, 0, 0, 0, 0, 1, 0, 0, 0);
    flush_all("fg");

    // Misaligned PC.
`ifdef IFETCH_ALIGN_CHECK_EN
    cyc("al.idle", 32'h6, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("al.fault", 32'h6, 0, 0, 0, 0, 0, 0, 0, 1);
    check("al.fault.fetch_fault", 64'(fetch_fault), 64'h1);
    check("al.fault.instr_pc", 64'(instr_pc), 64'h6);
    check("al.fault.instr", 64'(instr), 64'h0);
`else
    cyc("al.idle", 32'h6, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("al.req", 32'h6, 0, 0, 0, 0, 0, 1, 0, 0);
    check("al.req.mem_addr", 64'(mem_addr), 64'h4);
    check("al.req.fetch_fault", 64'(fetch_fault), 64'h0);
`endif
    flush_all("al");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC, issues one word read to instruction memory over a req/gnt + rvalid handshake, and buffers returned instructions with their PC in a small FIFO for the decoder.
- Drives `pc_advance` back to the PC stage.
- Discards wrong-path fetches on a taken-branch flush.

Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- FIFO_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  current PC from PC stage
- flush  in  1  taken branch/jump; drops all fetched and in-flight work
- pc_advance  out  1  one-cycle pulse: PC may take its next value
- mem_req  out  1  memory request valid
- mem_addr  out  ADDR_W  request address, word aligned
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- instr_valid  out  1  FIFO head valid
- instr  out  DATA_W  FIFO head instruction
- instr_pc  out  ADDR_W  FIFO head PC
- instr_ready  in  1  decoder consumes head when instr_valid & instr_ready
- fetch_fault  out  1  misaligned fetch flag (optional feature only, else tied 0)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, FIFO empty, count=0, drop=0.
  - Outputs: mem_req=0, mem_addr=0, pc_advance=0, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
- At most one outstanding request.
- FSM IDLE:
  - If !flush and (count + inflight) < FIFO_DEPTH, latch pc into req_pc and go to REQ.
  - Otherwise stay in IDLE.
- FSM REQ:
  - mem_req=1, mem_addr={req_pc[ADDR_W-1:2],2'b00}.
  - mem_addr is held stable until granted.
  - mem_gnt=1 -> go to WAIT; pc_advance=1 for exactly that cycle.
  - flush in REQ (with or without gnt):
    - no gnt -> IDLE, mem_req drops next cycle.
    - gnt -> WAIT with drop=1, and pc_advance is suppressed.
- FSM WAIT:
  - mem_rvalid=1 and drop=0 -> push {mem_rdata, req_pc}; go to IDLE.
  - mem_rvalid=1 and drop=1 -> discard, clear drop, go to IDLE.
  - flush in WAIT -> set drop=1 and remain in WAIT until rvalid.
  - rvalid and flush in the same cycle -> data discarded.
- Space reservation:
  - A request is only issued when a FIFO slot is reserved for it, so a response is never lost.
  - mem_rvalid is never back-pressured.
- FIFO:
  - Registered output; push-to-instr_valid latency is 1 cycle.
  - Minimum PC-to-instr_valid latency = 3 cycles with gnt and rvalid same cycle as request: IDLE->REQ, REQ->WAIT, WAIT push.
  - Simultaneous push and pop when full is allowed only as pop-then-push; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- flush:
  - Empties the FIFO next cycle: instr_valid=0, count=0.
  - A pop in the flush cycle is ignored.
  - The new-path request may start the cycle after flush deasserts.
- pc_advance never asserts while flush=1.
- Count never exceeds FIFO_DEPTH; push when full is impossible by construction (assertion in sim).

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- With the macro:
  - In IDLE, if pc[1:0]!=0 and a slot is free, no memory request is issued.
  - An entry {instr=0, instr_pc=pc} is pushed directly with fetch_fault sideband=1.
  - fetch_fault is valid with the head entry and travels through the FIFO.
  - FSM stays in IDLE; pc_advance is not pulsed (PC holds until a flush redirects it).
- Without the macro:
  - Low PC bits are ignored (address forced aligned); fetch_fault tied 0.

Test Plan:
- Reset then pc=0x0000_0000, mem_gnt=1, mem_rvalid one cycle after gnt with rdata=0x0000_0013, instr_ready=1 -> instr_valid=1 with instr=0x13, instr_pc=0x0; one pc_advance pulse per request.
- Streaming pc=0x0,0x4,0x8,0xC, gnt and rvalid always 1, ready=1 -> four instructions in order with matching instr_pc; FIFO never overflows.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 entries fetched, then mem_req stays 0 and pc_advance stays 0; release ready -> fetch resumes with pc=0x8.
- mem_gnt held 0 for 5 cycles -> mem_req=1 and mem_addr stable all 5 cycles; no pc_advance until gnt.
- flush in the WAIT cycle for pc=0x10, then rvalid rdata=0xDEAD_BEEF -> data dropped, instr_valid stays 0, FIFO empty; next fetch from redirected pc=0x40 returns correctly.
- With IFETCH_ALIGN_CHECK_EN, pc=0x0000_0006 -> no mem_req, instr_valid=1, fetch_fault=1, instr_pc=0x6, pc_advance=0; without the macro -> mem_addr=0x4, fetch_fault=0.
